// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state encoding and sizing helper shared by the serial adder
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - full adder composed of two half adders and an OR
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

    assign co = c0 | c1;

endmodule

// File: rtl/serial_adder_half_adder.sv
// rtl/serial_adder_half_adder.sv - combinational half-adder cell
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with valid/ready on both sides
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int                 CNT_W    = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             fa_s;
    logic             fa_c;

    fa_cell u_fa (
        .x (a_q[0]),
        .y (b_q[0]),
        .ci(carry_q),
        .s (fa_s),
        .co(fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d            = a_q >> 1;
                b_d            = b_q >> 1;
                // New bit enters at the MSB so the first bit lands at the LSB after WIDTH shifts.
                sum_d          = sum_q >> 1;
                sum_d[WIDTH-1] = fa_s;
                carry_d        = fa_c;
                cnt_d          = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for the 8-bit and 1-bit serial adder builds
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [7:0] a, b, sum;

    logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
    logic [0:0] a1, b1, sum1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic ci);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a = av; b = bv; cin = ci; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_valid8(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic [8:0] exp);
        int n;
        out_ready = 1'b1;
        start8(av, bv, ci);
        wait_valid8(n);
        check({tag, "_latency"}, n, 8);
        check({tag, "_sum"}, sum, exp[7:0]);
        check({tag, "_cout"}, cout, exp[8]);
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0;
        in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; out_ready1 = 0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_w1_in_ready", in_ready1, 1);

        // A request during reset must not be taken
        in_valid = 1'b1; a = 8'h12; b = 8'h34;
        @(negedge clk);
        @(negedge clk);
        check("rst_no_accept", busy, 0);
        in_valid = 1'b0;
        rst = 1'b0;

        run8("basic", 8'h5A, 8'h33, 1'b0, 9'h08D);
        run8("ripple1", 8'hFF, 8'h01, 1'b0, 9'h100);
        run8("ripple2", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        run8("msb_carry", 8'h80, 8'h80, 1'b0, 9'h100);
        run8("cin_only", 8'h00, 8'h00, 1'b1, 9'h001);

        // Back-pressure
        out_ready = 1'b0;
        start8(8'h10, 8'h20, 1'b1);
        wait_valid8(n);
        check("bp_latency", n, 8);
        repeat (5) begin
            check("bp_valid", out_valid, 1);
            check("bp_sum", sum, 8'h31);
            check("bp_cout", cout, 0);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("bp_valid_last", out_valid, 1);
        @(negedge clk);
        check("bp_ready_back", in_ready, 1);
        check("bp_valid_drop", out_valid, 0);

        // Input pulse while running is ignored
        start8(8'h01, 8'h02, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0;
        wait_valid8(n);
        check("ign_latency", n, 5);
        check("ign_sum", sum, 8'h03);
        check("ign_cout", cout, 0);
        @(negedge clk);
        seen = 0;
        repeat (15) begin
            if (out_valid || busy) seen++;
            @(negedge clk);
        end
        check("ign_no_second", seen, 0);

        // Reset in the middle of a run
        start8(8'hF0, 8'h0F, 1'b0);
        repeat (4) @(negedge clk);
        check("mid_partial_sum", sum, 8'hF0);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("mid_rst_no_valid", seen, 0);
        run8("after_rst", 8'h01, 8'h01, 1'b0, 9'h002);

        // WIDTH=1 build, every input combination
        out_ready1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] exp1;
            v = 3'(i);
            exp1 = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
            @(negedge clk);
            a1 = v[0]; b1 = v[1]; cin1 = v[2]; in_valid1 = 1'b1;
            @(negedge clk);
            in_valid1 = 1'b0;
            n = 0;
            while (!out_valid1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("w1_latency_%0d", i), n, 1);
            check($sformatf("w1_result_%0d", i), {cout1, sum1}, exp1);
            @(negedge clk);
            check($sformatf("w1_valid_drop_%0d", i), out_valid1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
